// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: dual-issue PC with one branch delay slot pair.
// Ports: clk, reset(sync low), int_req/exc_pc, stall, br_* handshake,
//        imem_req/addr/ack, fetch_valid/pc, flush, addr_err.
module fetch_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic [31:0] exc_pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        br_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        flush,
  output logic        addr_err
);

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } state_t;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] tgt;
  logic [31:0] tgt_n;
  logic        aerr_n;
  logic        done;
  logic        accept;
  logic        tgt_bad;
  logic        exc_bad;

  // imem_req already folds in stall and reset
  assign done    = imem_ack & imem_req & ~int_req;
  assign accept  = br_valid & br_ready;
  assign tgt_bad = |br_target[2:0];
  assign exc_bad = |exc_pc[2:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RST_PC;
      tgt         <= '0;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      flush       <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      tgt         <= tgt_n;
      fetch_valid <= done;
      flush       <= int_req;
      addr_err    <= aerr_n;
      if (done)
        fetch_pc  <= pc;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    aerr_n  = 1'b0;
    if (int_req) begin
      state_n = RUN;
      tgt_n   = '0;
      aerr_n  = exc_bad;
      pc_n    = exc_bad ? EXC_PC : exc_pc;
    end else if (accept && tgt_bad) begin
      // bad target is dropped, fetch stays sequential
      aerr_n  = 1'b1;
      if (done)
        pc_n  = pc + 32'd8;
    end else if (accept && done) begin
      // this fetch is the delay-slot pair
      pc_n    = br_target;
    end else if (accept) begin
      state_n = SLOT;
      tgt_n   = br_target;
    end else if (done && state == SLOT) begin
      state_n = RUN;
      pc_n    = tgt;
      tgt_n   = '0;
    end else if (done) begin
      pc_n    = pc + 32'd8;
    end
  end

  always_comb begin
    imem_req  = ~stall & reset;
    imem_addr = pc;
    br_ready  = (state == RUN) & ~int_req;
  end

endmodule
